// File: rtl/x_top_arb.sv
// Two-requester round-robin arbiter for the x_top memory bus.
// One transaction in flight at a time; all outputs are registered. A watchdog
// aborts a downstream request that is never accepted and reports it as an error.
module x_top_arb #(
  parameter int unsigned p_timeout = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  input  logic [1:0]  i_req_rnw,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_data,
  output logic [1:0]  o_req_accept,
  output logic [31:0] o_req_data,
  output logic [1:0]  o_req_err,
  output logic        o_mem_valid,
  output logic        o_mem_rnw,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_accept,
  input  logic [31:0] i_mem_data,
  output logic        o_grant
);

  localparam int unsigned TimerW = (p_timeout == 0) ? 1 : $clog2(p_timeout + 1);
  localparam logic [TimerW-1:0] TimerLast = (p_timeout == 0) ? '0 : TimerW'(p_timeout - 1);
  localparam logic [TimerW-1:0] TimerMax  = '1;
  localparam logic WatchdogOn = (p_timeout != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q;
  logic              ptr_q;
  logic [TimerW-1:0] timer_q;

  logic        win;
  logic [1:0]  grant_onehot;
  logic [31:0] win_addr;
  logic [31:0] win_data;

  // Winner selection: the pointer only matters when both requesters are valid.
  always_comb begin
    win          = (i_req_valid == 2'b11) ? ptr_q : i_req_valid[1];
    win_addr     = win ? i_req_addr[63:32] : i_req_addr[31:0];
    win_data     = win ? i_req_data[63:32] : i_req_data[31:0];
    grant_onehot = o_grant ? 2'b10 : 2'b01;
  end

  // Arbiter FSM with registered bus and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      timer_q      <= '0;
      o_req_accept <= 2'b00;
      o_req_data   <= '0;
      o_req_err    <= 2'b00;
      o_mem_valid  <= 1'b0;
      o_mem_rnw    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_grant      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|i_req_valid) begin
            o_grant     <= win;
            o_mem_valid <= 1'b1;
            o_mem_rnw   <= i_req_rnw[win];
            o_mem_addr  <= win_addr;
            o_mem_data  <= win_data;
            timer_q     <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          // Saturating count so a long wait can never wrap back below the limit.
          if (timer_q != TimerMax) timer_q <= timer_q + 1'b1;
          // Accept takes precedence over a watchdog expiry in the same cycle.
          if (i_mem_accept) begin
            o_mem_valid  <= 1'b0;
            o_req_accept <= grant_onehot;
            o_req_data   <= i_mem_data;
            state_q      <= StResp;
          end else if (WatchdogOn && (timer_q == TimerLast)) begin
            o_mem_valid  <= 1'b0;
            o_req_accept <= grant_onehot;
            o_req_err    <= grant_onehot;
            o_req_data   <= '0;
            state_q      <= StResp;
          end
        end
        StResp: begin
          o_req_accept <= 2'b00;
          o_req_err    <= 2'b00;
          o_req_data   <= '0;
          ptr_q        <= ~o_grant;
          timer_q      <= '0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_x_top_arb.sv
// Bench for x_top_arb: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_x_top_arb;

  localparam int unsigned TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req_valid;
  logic [1:0]  i_req_rnw;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_data;
  logic [1:0]  o_req_accept;
  logic [31:0] o_req_data;
  logic [1:0]  o_req_err;
  logic        o_mem_valid;
  logic        o_mem_rnw;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        i_mem_accept;
  logic [31:0] i_mem_data;
  logic        o_grant;

  x_top_arb #(.p_timeout(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_rnw   (i_req_rnw),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_req_accept(o_req_accept),
    .o_req_data  (o_req_data),
    .o_req_err   (o_req_err),
    .o_mem_valid (o_mem_valid),
    .o_mem_rnw   (o_mem_rnw),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .i_mem_accept(i_mem_accept),
    .i_mem_data  (i_mem_data),
    .o_grant     (o_grant)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a request, 1 = request outstanding downstream,
  // 2 = response cycle. m_wait counts downstream cycles already spent unaccepted.
  int          m_phase = 0;
  int          m_wait  = 0;
  bit          m_who   = 0;
  bit          m_ptr   = 0;
  bit          m_err   = 0;
  bit          m_rnw   = 0;
  bit [31:0]   m_addr  = 0;
  bit [31:0]   m_wdat  = 0;
  bit [31:0]   m_res   = 0;

  always @(posedge i_clk) begin : model
    bit w;
    if (i_rst) begin
      m_phase <= 0; m_wait <= 0; m_who <= 0; m_ptr <= 0; m_err <= 0;
      m_rnw <= 0; m_addr <= 0; m_wdat <= 0; m_res <= 0;
    end else if (m_phase == 0) begin
      if (i_req_valid != 2'b00) begin
        w = (i_req_valid == 2'b11) ? m_ptr : i_req_valid[1];
        m_who   <= w;
        m_rnw   <= i_req_rnw[w];
        m_addr  <= i_req_addr[32*w +: 32];
        m_wdat  <= i_req_data[32*w +: 32];
        m_wait  <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (i_mem_accept) begin
        m_res <= i_mem_data; m_err <= 0; m_phase <= 2;
      end else if (TO != 0 && m_wait + 1 == TO) begin
        m_res <= 0; m_err <= 1; m_phase <= 2;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else begin
      m_ptr   <= ~m_who;
      m_phase <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    logic [1:0] who_bit;
    if (chk_en) begin
      who_bit = m_who ? 2'b10 : 2'b01;
      chk("mem_valid", o_mem_valid, m_phase == 1);
      chk("mem_rnw", o_mem_rnw, m_rnw);
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_data", o_mem_data, m_wdat);
      chk("grant", o_grant, m_who);
      chk("req_accept", o_req_accept, (m_phase == 2) ? who_bit : 2'b00);
      chk("req_err", o_req_err, (m_phase == 2 && m_err) ? who_bit : 2'b00);
      chk("req_data", o_req_data, (m_phase == 2) ? m_res : 32'h0);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int cnt;
    i_rst = 1'b1; i_req_valid = 0; i_req_rnw = 0; i_req_addr = 0; i_req_data = 0;
    i_mem_accept = 0; i_mem_data = 0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_mem_valid", o_mem_valid, 0);
    chk("reset_accept", o_req_accept, 0);
    chk("reset_grant", o_grant, 0);
    i_rst = 1'b0;

    // Single read from requester 0.
    i_req_valid = 2'b01; i_req_rnw = 2'b01; i_req_addr = 64'h100;
    step();
    chk("rd_mem_valid", o_mem_valid, 1);
    chk("rd_mem_addr", o_mem_addr, 32'h100);
    chk("rd_mem_rnw", o_mem_rnw, 1);
    step(); step();
    i_mem_accept = 1; i_mem_data = 32'hCAFEF00D;
    step();
    chk("rd_accept", o_req_accept, 2'b01);
    chk("rd_data", o_req_data, 32'hCAFEF00D);
    i_mem_accept = 0; i_req_valid = 0;
    step();
    chk("rd_accept_gone", o_req_accept, 0);

    // Tie with immediate accepts: grants alternate starting from pointer 0.
    i_rst = 1; step(); i_rst = 0;
    i_req_valid = 2'b11; i_req_rnw = 2'b11; i_req_addr = 64'h0000_0B00_0000_0A00;
    i_mem_accept = 1; i_mem_data = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_valid", o_mem_valid, 1);
      chk("rr_grant", o_grant, k % 2);
      step();
      chk("rr_accept", o_req_accept, (k % 2) ? 2'b10 : 2'b01);
      step();
    end
    i_mem_accept = 0; i_req_valid = 0;
    step();

    // Write from requester 1; outputs stay put while the request inputs wander.
    i_req_valid = 2'b10; i_req_rnw = 2'b00;
    i_req_addr = {32'h2000_0004, 32'h0}; i_req_data = {32'h0000_005A, 32'h0};
    step();
    i_req_valid = 2'b00; i_req_addr = 64'hFFFF_FFFF_FFFF_FFFF; i_req_data = '1;
    for (int k = 0; k < 3; k++) begin
      chk("wr_mem_data", o_mem_data, 32'h5A);
      chk("wr_mem_rnw", o_mem_rnw, 0);
      chk("wr_mem_addr", o_mem_addr, 32'h2000_0004);
      step();
    end
    i_mem_accept = 1;
    step();
    chk("wr_accept", o_req_accept, 2'b10);
    i_mem_accept = 0;
    step();

    // Watchdog: memory never accepts.
    i_req_valid = 2'b01; i_req_rnw = 0; i_req_addr = 64'h44;
    step();
    cnt = 0;
    for (int i = 0; i < 20 && o_req_accept == 2'b00; i++) begin
      if (o_mem_valid) cnt++;
      step();
    end
    chk("wd_valid_cycles", cnt, TO);
    chk("wd_accept", o_req_accept, 2'b01);
    chk("wd_err", o_req_err, 2'b01);
    chk("wd_data", o_req_data, 0);
    i_req_valid = 0;
    step();

    // Accept arrives on the same cycle the watchdog would fire.
    i_req_valid = 2'b01;
    step();
    i_req_valid = 0;
    for (int i = 0; i < TO - 1; i++) step();
    i_mem_accept = 1; i_mem_data = 32'h1234_5678;
    step();
    chk("race_accept", o_req_accept, 2'b01);
    chk("race_err", o_req_err, 2'b00);
    chk("race_data", o_req_data, 32'h1234_5678);
    i_mem_accept = 0;
    step();

    // Reset in the middle of a transaction, then a stray accept.
    i_req_valid = 2'b10;
    step(); step();
    i_rst = 1;
    step();
    chk("rst_mem_valid", o_mem_valid, 0);
    chk("rst_accept", o_req_accept, 0);
    chk("rst_addr", o_mem_addr, 0);
    i_rst = 0; i_req_valid = 0; i_mem_accept = 1;
    step(); step();
    chk("stray_accept", o_req_accept, 0);
    chk("stray_valid", o_mem_valid, 0);
    i_mem_accept = 0; i_req_valid = 2'b11;
    step();
    chk("rst_ptr_grant", o_grant, 0);
    i_mem_accept = 1;
    step();
    i_mem_accept = 0; i_req_valid = 0;
    step();

    // Random traffic: requesters hold until accepted, memory accepts at random.
    for (int c = 0; c < 4000; c++) begin
      i_rst = ($urandom_range(0, 599) == 0);
      i_mem_accept = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      i_mem_data = $urandom;
      for (int n = 0; n < 2; n++) begin
        if (i_req_valid[n] && o_req_accept[n]) begin
          i_req_valid[n] = 1'b0;
        end else if (!i_req_valid[n] && $urandom_range(0, 3) == 0) begin
          i_req_valid[n] = 1'b1;
          i_req_rnw[n] = 1'($urandom);
          i_req_addr[32*n +: 32] = $urandom;
          i_req_data[32*n +: 32] = $urandom;
        end
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
